mem_autoconfig: RTL and testbench
=================================

Name: mem_autoconfig

Overview:
- Consumes the latched memory-mode flags (8MB / 4MB / slow / slow+4MB) from the jumper-reading stage.
- Presents the Zorro II AutoConfig nibble space at $E80000 to the 68000 when a fast-RAM mode is selected.
- Accepts the base address the OS assigns, then produces the RAM select strobes used by the DRAM controller.
- Handles the slow-RAM window and the "no expansion" pass-through.

Parameters:
- MANUF_ID, 16'h07DB, manufacturer number presented at offsets $10–$16.
- PRODUCT_ID, 8'h01, product number presented at offsets $04–$06.
- SLOW_BASE, 4'hC, A23..A20 of the fixed slow window ($C00000–$D7FFFF).

Ports:
- clock  in  1  system clock, all logic on the rising edge.
- reset  in  1  asynchronous, active-high; clears every register.
- mode_8mb  in  1  jumper mode: 8MB fast RAM.
- mode_4mb  in  1  jumper mode: 4MB fast RAM.
- mode_slow  in  1  jumper mode: slow window only.
- mode_slow4mb  in  1  jumper mode: slow window plus 4MB fast RAM.
- cfgin_n  in  1  AutoConfig chain input, low = our turn.
- as_n  in  1  68000 address strobe (async; sync internally).
- uds_n  in  1  upper data strobe (async; sync internally).
- rw  in  1  1 = read, 0 = write.
- addr  in  23  A23..A1.
- data_in  in  4  D15..D12.
- data_out  out  4  nibble driven on D15..D12.
- data_oe  out  1  drive D15..D12.
- cfgout_n  out  1  AutoConfig chain output.
- fast_sel  out  1  cycle hits configured fast RAM.
- slow_sel  out  1  cycle hits slow window.
- configured  out  1  base address accepted.

Behaviour:
- Reset values:
  - data_out=0, data_oe=0, fast_sel=0, slow_sel=0, configured=0, cfgout_n=1.
  - base=0, state=WAIT.
- Synchronisers: as_n, uds_n and cfgin_n each pass through 2 flops (as_s, uds_s, cfgin_s). Raw addr/rw/data_in are sampled only on the cycle start.
- Cycle start: as_s=0 and uds_s=0 while cycle_active=0. That cycle sets cycle_active=1. cycle_active clears on the first cycle with as_s=1.
- Mode latch: in WAIT, when cfgin_s=0, latch the four mode bits into cfg_mode. cfg_mode is then frozen until reset.
  - The fast size is 8MB if mode_8mb, 4MB if mode_4mb or mode_slow4mb, otherwise none.
  - If more than one bit is set, priority is 8mb > 4mb > slow4mb > slow.
- FSM:
  - WAIT: on cfgin_s=0 go to AUTOCONF if a fast size exists, else go to PASS.
  - AUTOCONF: responds to $E80000–$E8007F.
    - Write to $E80048 (A6..A1=6'h24): base=data_in, configured=1, go to DONE.
    - Write to $E8004C: shut up, go to PASS with configured=0.
    - Write to $E8004A: stores the low nibble, no effect otherwise.
  - DONE and PASS are terminal until reset.
  - cfgout_n=0 in DONE and PASS; 1 otherwise.
- AutoConfig reads, AUTOCONF only; index = addr[6:1]. The value listed is the raw nibble; every offset except $00/$02 is output inverted.
  - $00: 4'hE (Zorro II, add to free list, no ROM).
  - $02: 4'h0 for 8MB, 4'h7 for 4MB.
  - $04/$06: PRODUCT_ID[7:4]/[3:0].
  - $08: 4'h0; $0A: 4'h0.
  - $10/$12/$14/$16: MANUF_ID nibbles, MSB first.
  - All other offsets: raw 4'h0, which reads as F after inversion.
  - $40 and above read 4'h0 uninverted.
- Read data latency: data_out and data_oe are registered one cycle after the cycle start. data_oe falls on the first cycle with as_s=1.
- Writes in any state other than AUTOCONF are ignored. A write to $E80048 in DONE does not re-base.
- Decode, registered once per cycle start and cleared when as_s=1:
  - fast_sel=1 when configured and addr[23:20] falls in the range below.
    - 8MB: addr[23:20] in base..base+7.
    - 4MB: addr[23:20] in base..base+3.
    - The comparison is 4-bit with no wrap: if base+size exceeds F, only addresses up to F match.
  - slow_sel=1 when cfg_mode is slow or slow4mb and addr[23:16] is in SLOW_BASE0..SLOW_BASE0+0x17.
  - fast_sel and slow_sel are never both 1; fast_sel wins.
- Reset mid-cycle: all outputs are forced to reset values immediately and asynchronously. The bus cycle is not completed by this block.

Test Plan:
- mode_8mb=1, cfgin_n=0, read $E80000 and $E80002 -> data_out=E then 0, data_oe one cycle after start; read $E80004 -> ~0=F.
- mode_4mb=1, read $E80002 -> 7; read $E80010 -> ~0=F, $E80012 -> ~7=8 (MANUF_ID=07DB).
- 8MB, write D15..D12=2 to $E80048 -> configured=1, cfgout_n=0; read $200000 -> fast_sel=1; $9FFFFE -> 1; $A00000 -> 0.
- mode_slow=1, cfgin_n=0 -> PASS, cfgout_n=0, no data_oe on $E80000; $C80000 -> slow_sel=1; $D80000 -> 0.
- 4MB, write $E8004C -> PASS, configured=0, fast_sel never asserts; later write $E80048 ignored.
- Assert reset while data_oe=1 -> data_oe=0 the same cycle; state WAIT; cfgout_n=1.

Source files
------------

// File: rtl/mem_autoconfig.sv
// Zorro II AutoConfig responder and RAM select decoder for a jumper-selected
// fast/slow memory expansion sitting behind a 68000 bus.
module mem_autoconfig #(
  parameter logic [15:0] MANUF_ID   = 16'h07DB,
  parameter logic [7:0]  PRODUCT_ID = 8'h01,
  parameter logic [3:0]  SLOW_BASE  = 4'hC
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        mode_8mb,
  input  logic        mode_4mb,
  input  logic        mode_slow,
  input  logic        mode_slow4mb,
  input  logic        cfgin_n,
  input  logic        as_n,
  input  logic        uds_n,
  input  logic        rw,
  input  logic [23:1] addr,
  input  logic [3:0]  data_in,
  output logic [3:0]  data_out,
  output logic        data_oe,
  output logic        cfgout_n,
  output logic        fast_sel,
  output logic        slow_sel,
  output logic        configured
);

  typedef enum logic [1:0] {ST_WAIT, ST_AUTOCONF, ST_DONE, ST_PASS} state_t;
  typedef enum logic [2:0] {MODE_NONE, MODE_8MB, MODE_4MB, MODE_SLOW4MB, MODE_SLOW} mode_t;

  state_t     state;
  mode_t      cfg_mode;
  logic [3:0] base;
  logic       as_m, as_s, uds_m, uds_s, cfgin_m, cfgin_s;
  logic       cycle_active;

  // NOTE: synchronisers reset to the idle (high) level so leaving reset can never look like a bus cycle or a chain grant.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      as_m    <= 1'b1;
      as_s    <= 1'b1;
      uds_m   <= 1'b1;
      uds_s   <= 1'b1;
      cfgin_m <= 1'b1;
      cfgin_s <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments let each stage see the previous stage's old value, forming a real two-flop chain.
      as_m    <= as_n;
      as_s    <= as_m;
      uds_m   <= uds_n;
      uds_s   <= uds_m;
      cfgin_m <= cfgin_n;
      cfgin_s <= cfgin_m;
    end
  end

  mode_t      mode_next;
  logic       has_fast_next;
  logic [3:0] fast_size;
  logic       slow_en;

  always_comb begin
    // NOTE: every variable gets a default before any branch so no path infers a latch.
    mode_next = MODE_NONE;
    if (mode_8mb)          mode_next = MODE_8MB;
    else if (mode_4mb)     mode_next = MODE_4MB;
    else if (mode_slow4mb) mode_next = MODE_SLOW4MB;
    else if (mode_slow)    mode_next = MODE_SLOW;
    has_fast_next = mode_8mb | mode_4mb | mode_slow4mb;

    fast_size = 4'd0;
    slow_en   = 1'b0;
    case (cfg_mode)
      MODE_8MB:     fast_size = 4'd8;
      MODE_4MB:     fast_size = 4'd4;
      MODE_SLOW4MB: begin fast_size = 4'd4; slow_en = 1'b1; end
      MODE_SLOW:    slow_en = 1'b1;
      default:      ;
    endcase
  end

  logic       cycle_start;
  logic       ac_hit;
  logic [5:0] ac_idx;
  logic [3:0] ac_raw, ac_nibble;

  assign cycle_start = !as_s && !uds_s && !cycle_active;
  assign ac_hit      = (addr[23:16] == 8'hE8) && (addr[15:7] == 9'd0);
  assign ac_idx      = addr[6:1];

  always_comb begin
    ac_raw = 4'h0;
    case (ac_idx)
      6'h00:   ac_raw = 4'hE;
      6'h01:   ac_raw = (cfg_mode == MODE_8MB) ? 4'h0 : 4'h7;
      6'h02:   ac_raw = PRODUCT_ID[7:4];
      6'h03:   ac_raw = PRODUCT_ID[3:0];
      6'h08:   ac_raw = MANUF_ID[15:12];
      6'h09:   ac_raw = MANUF_ID[11:8];
      6'h0A:   ac_raw = MANUF_ID[7:4];
      6'h0B:   ac_raw = MANUF_ID[3:0];
      default: ac_raw = 4'h0;
    endcase
    // Only $00/$02 and the register area from $40 up are presented uninverted.
    ac_nibble = (ac_idx < 6'h02 || ac_idx >= 6'h20) ? ac_raw : ~ac_raw;
  end

  // 4-bit segment compare widened to 5 bits so a window running past $F simply stops there.
  logic [4:0] seg, fast_lo, fast_end;
  logic [8:0] page, slow_lo, slow_hi;
  logic       fast_hit, slow_hit;

  assign seg      = {1'b0, addr[23:20]};
  assign fast_lo  = {1'b0, base};
  assign fast_end = fast_lo + {1'b0, fast_size};
  assign fast_hit = configured && (seg >= fast_lo) && (seg < fast_end);
  assign page     = {1'b0, addr[23:16]};
  assign slow_lo  = {1'b0, SLOW_BASE, 4'h0};
  assign slow_hi  = slow_lo + 9'h017;
  assign slow_hit = slow_en && (page >= slow_lo) && (page <= slow_hi);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= ST_WAIT;
      cfg_mode     <= MODE_NONE;
      base         <= 4'h0;
      cycle_active <= 1'b0;
      data_out     <= 4'h0;
      data_oe      <= 1'b0;
      cfgout_n     <= 1'b1;
      fast_sel     <= 1'b0;
      slow_sel     <= 1'b0;
      configured   <= 1'b0;
    end else begin
      if (as_s) begin
        cycle_active <= 1'b0;
        data_oe      <= 1'b0;
        fast_sel     <= 1'b0;
        slow_sel     <= 1'b0;
      end else if (cycle_start) begin
        cycle_active <= 1'b1;
        fast_sel     <= fast_hit;
        slow_sel     <= slow_hit && !fast_hit;
        if (state == ST_AUTOCONF && ac_hit && rw) begin
          data_oe  <= 1'b1;
          data_out <= ac_nibble;
        end
      end

      case (state)
        ST_WAIT: begin
          if (!cfgin_s) begin
            cfg_mode <= mode_next;
            if (has_fast_next) begin
              state <= ST_AUTOCONF;
            end else begin
              state    <= ST_PASS;
              cfgout_n <= 1'b0;
            end
          end
        end
        ST_AUTOCONF: begin
          if (cycle_start && ac_hit && !rw) begin
            // The low base nibble at $4A is accepted silently: this board maps on 1MB boundaries.
            case (ac_idx)
              6'h24: begin
                base       <= data_in;
                configured <= 1'b1;
                state      <= ST_DONE;
                cfgout_n   <= 1'b0;
              end
              6'h26: begin
                state    <= ST_PASS;
                cfgout_n <= 1'b0;
              end
              default: ;
            endcase
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_autoconfig.sv
// Randomised bench for mem_autoconfig: AutoConfig reads, base assignment,
// fast/slow decode, shut-up, mode priority and asynchronous reset.
module tb_mem_autoconfig;

  localparam logic [15:0] MANUF   = 16'h07DB;
  localparam logic [7:0]  PRODUCT = 8'h01;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        mode_8mb = 1'b0, mode_4mb = 1'b0, mode_slow = 1'b0, mode_slow4mb = 1'b0;
  logic        cfgin_n = 1'b1, as_n = 1'b1, uds_n = 1'b1, rw = 1'b1;
  logic [23:1] addr = '0;
  logic [3:0]  data_in = 4'h0;
  logic [3:0]  data_out;
  logic        data_oe, cfgout_n, fast_sel, slow_sel, configured;

  mem_autoconfig dut (
    .clock(clock), .reset(reset),
    .mode_8mb(mode_8mb), .mode_4mb(mode_4mb), .mode_slow(mode_slow), .mode_slow4mb(mode_slow4mb),
    .cfgin_n(cfgin_n), .as_n(as_n), .uds_n(uds_n), .rw(rw), .addr(addr), .data_in(data_in),
    .data_out(data_out), .data_oe(data_oe), .cfgout_n(cfgout_n),
    .fast_sel(fast_sel), .slow_sel(slow_sel), .configured(configured)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_err = 0;

  // Reference state: mode bits {8mb,4mb,slow4mb,slow} as latched, plus assigned base.
  logic [3:0] m_mode = 4'h0;
  bit         m_cfg  = 1'b0;
  logic [3:0] m_base = 4'h0;

  logic       obs_early_oe, obs_oe, obs_fast, obs_slow;
  logic [3:0] obs_data;
  logic [2:0] obs_after;

  function automatic int model_size(input logic [3:0] m);
    if (m[3]) return 8;
    if (m[2] || m[1]) return 4;
    return 0;
  endfunction

  function automatic bit model_slow_win(input logic [3:0] m);
    return !m[3] && !m[2] && (m[1] || m[0]);
  endfunction

  function automatic bit model_fast(input int a);
    int lo, hi;
    if (!m_cfg) return 1'b0;
    lo = int'(m_base) * (1 << 20);
    hi = lo + model_size(m_mode) * (1 << 20);
    if (hi > (1 << 24)) hi = 1 << 24;
    return (a >= lo) && (a < hi);
  endfunction

  function automatic bit model_slow(input int a);
    return model_slow_win(m_mode) && (a >= 'hC00000) && (a < 'hD80000) && !model_fast(a);
  endfunction

  function automatic logic [3:0] model_nibble(input int size, input int off);
    logic [3:0] raw;
    raw = 4'h0;
    if (off >= 'h40) return 4'h0;
    case (off)
      'h00: raw = 4'hE;
      'h02: raw = (size == 8) ? 4'h0 : 4'h7;
      'h04: raw = PRODUCT[7:4];
      'h06: raw = PRODUCT[3:0];
      'h10: raw = MANUF[15:12];
      'h12: raw = MANUF[11:8];
      'h14: raw = MANUF[7:4];
      'h16: raw = MANUF[3:0];
      default: raw = 4'h0;
    endcase
    return (off <= 2) ? raw : ~raw;
  endfunction

  function automatic int rand_addr();
    int a;
    a = int'($urandom_range(0, 'hFFFFFF));
    return a & ~1;
  endfunction

  task automatic start_mode(input logic [3:0] m);
    @(negedge clock);
    reset = 1'b1; cfgin_n = 1'b1; as_n = 1'b1; uds_n = 1'b1;
    {mode_8mb, mode_4mb, mode_slow4mb, mode_slow} = m;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    cfgin_n = 1'b0;
    repeat (4) @(negedge clock);
    m_mode = m; m_cfg = 1'b0; m_base = 4'h0;
  endtask

  task automatic bus(input int a, input logic is_read, input logic [3:0] wd);
    logic [23:0] ba;
    ba = a[23:0];
    @(negedge clock);
    addr = ba[23:1]; rw = is_read; data_in = wd; as_n = 1'b0; uds_n = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    obs_early_oe = data_oe;
    @(posedge clock);
    @(negedge clock);
    obs_oe = data_oe; obs_data = data_out; obs_fast = fast_sel; obs_slow = slow_sel;
    as_n = 1'b1; uds_n = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    obs_after = {data_oe, fast_sel, slow_sel};
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clock);
    n_cmp++;
    if ({data_out, data_oe, fast_sel, slow_sel} !== 7'b0) begin
      n_err++;
      $display("FAIL reset_data_sel: got %b want 0000000", {data_out, data_oe, fast_sel, slow_sel});
    end
    n_cmp++;
    if ({configured, cfgout_n} !== 2'b01) begin
      n_err++;
      $display("FAIL reset_cfg: got configured/cfgout_n=%b want 01", {configured, cfgout_n});
    end
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_autoconf_reads();
    logic [3:0] modes [3];
    logic [3:0] exp;
    int a;
    modes[0] = 4'b1000; modes[1] = 4'b0100; modes[2] = 4'b0010;
    for (int k = 0; k < 3; k++) begin
      start_mode(modes[k]);
      n_cmp++;
      if ({configured, cfgout_n} !== 2'b01) begin
        n_err++;
        $display("FAIL autoconf_entry mode=%b: got %b want 01", modes[k], {configured, cfgout_n});
      end
      for (int off = 0; off < 'h80; off += 2) begin
        bus('hE80000 + off, 1'b1, 4'h0);
        exp = model_nibble(model_size(m_mode), off);
        n_cmp++;
        if (obs_early_oe !== 1'b0) begin
          n_err++;
          $display("FAIL read_latency off=%h: data_oe early got %b want 0", off, obs_early_oe);
        end
        n_cmp++;
        if ({obs_oe, obs_data} !== {1'b1, exp}) begin
          n_err++;
          $display("FAIL ac_read mode=%b off=%h: got oe=%b d=%h want oe=1 d=%h", modes[k], off, obs_oe, obs_data, exp);
        end
        n_cmp++;
        if (obs_after[2] !== 1'b0) begin
          n_err++;
          $display("FAIL oe_release off=%h: got %b want 0", off, obs_after[2]);
        end
      end
      for (int j = 0; j < 5; j++) begin
        if (j == 0) a = 'hE80080;
        else if (j == 1) a = 'hE90000;
        else a = rand_addr();
        if (a[23:16] == 8'hE8 && a[15:7] == 9'd0) a = a ^ 'h010000;
        bus(a, 1'b1, 4'h0);
        n_cmp++;
        if ({obs_oe, obs_fast, obs_slow} !== {1'b0, 1'b0, model_slow(a)}) begin
          n_err++;
          $display("FAIL ac_outside @%h: got oe/fast/slow=%b want 00%b", a, {obs_oe, obs_fast, obs_slow}, model_slow(a));
        end
      end
    end
  endtask

  task automatic test_configure();
    logic [3:0] m, b;
    int lo, hi, a;
    int addrs [$];
    for (int it = 0; it < 6; it++) begin
      if (it == 0) begin m = 4'b1000; b = 4'h2; end
      else if (it == 1) begin m = 4'b1000; b = 4'hE; end
      else begin
        case ($urandom_range(0, 2))
          0: m = 4'b1000;
          1: m = 4'b0100;
          default: m = 4'b0010;
        endcase
        b = 4'($urandom_range(0, 15));
      end
      start_mode(m);
      bus('hE8004A, 1'b0, 4'($urandom_range(0, 15)));
      n_cmp++;
      if ({configured, cfgout_n} !== 2'b01) begin
        n_err++;
        $display("FAIL low_nibble_write: got %b want 01", {configured, cfgout_n});
      end
      bus('hE80048, 1'b0, b);
      m_cfg = 1'b1; m_base = b;
      n_cmp++;
      if ({configured, cfgout_n} !== 2'b10) begin
        n_err++;
        $display("FAIL base_write b=%h: got %b want 10", b, {configured, cfgout_n});
      end
      lo = int'(b) * (1 << 20);
      hi = lo + model_size(m) * (1 << 20);
      addrs.delete();
      addrs.push_back(lo);
      if (lo > 0) addrs.push_back(lo - 2);
      if (hi < (1 << 24)) begin addrs.push_back(hi - 2); addrs.push_back(hi); end
      else addrs.push_back('hFFFFFE);
      for (int j = 0; j < 8; j++) addrs.push_back(rand_addr());
      foreach (addrs[j]) begin
        a = addrs[j];
        bus(a, 1'b1, 4'h0);
        n_cmp++;
        if ({obs_oe, obs_fast, obs_slow} !== {1'b0, model_fast(a), model_slow(a)}) begin
          n_err++;
          $display("FAIL decode b=%h @%h: got oe/fast/slow=%b want 0%b%b", b, a, {obs_oe, obs_fast, obs_slow}, model_fast(a), model_slow(a));
        end
        n_cmp++;
        if (obs_after[1:0] !== 2'b00) begin
          n_err++;
          $display("FAIL sel_release @%h: got %b want 00", a, obs_after[1:0]);
        end
      end
      bus('hE80048, 1'b0, b ^ 4'h5);
      bus(lo, 1'b1, 4'h0);
      n_cmp++;
      if ({configured, obs_fast} !== {1'b1, model_fast(lo)}) begin
        n_err++;
        $display("FAIL no_rebase b=%h: got cfg/fast=%b want 1%b", b, {configured, obs_fast}, model_fast(lo));
      end
    end
  endtask

  task automatic test_slow_pass();
    int a;
    int addrs [$];
    start_mode(4'b0001);
    n_cmp++;
    if ({configured, cfgout_n} !== 2'b00) begin
      n_err++;
      $display("FAIL slow_pass_state: got %b want 00", {configured, cfgout_n});
    end
    bus('hE80000, 1'b1, 4'h0);
    n_cmp++;
    if (obs_oe !== 1'b0) begin
      n_err++;
      $display("FAIL slow_no_ac: data_oe got %b want 0", obs_oe);
    end
    addrs = '{'hC80000, 'hD80000, 'hC00000, 'hBFFFFE, 'hD7FFFE};
    for (int j = 0; j < 8; j++) addrs.push_back(int'($urandom_range('hB00000, 'hDFFFFF)) & ~1);
    foreach (addrs[j]) begin
      a = addrs[j];
      bus(a, 1'b1, 4'h0);
      n_cmp++;
      if ({obs_fast, obs_slow} !== {1'b0, model_slow(a)}) begin
        n_err++;
        $display("FAIL slow_decode @%h: got fast/slow=%b want 0%b", a, {obs_fast, obs_slow}, model_slow(a));
      end
    end
    bus('hE80048, 1'b0, 4'h3);
    n_cmp++;
    if (configured !== 1'b0) begin
      n_err++;
      $display("FAIL pass_write_ignored: configured got %b want 0", configured);
    end
  endtask

  task automatic test_shutup();
    logic [3:0] m;
    int a;
    m = ($urandom_range(0, 1) == 0) ? 4'b0100 : 4'b0010;
    start_mode(m);
    bus('hE8004C, 1'b0, 4'h0);
    n_cmp++;
    if ({configured, cfgout_n} !== 2'b00) begin
      n_err++;
      $display("FAIL shutup: got %b want 00", {configured, cfgout_n});
    end
    bus('hE80048, 1'b0, 4'($urandom_range(0, 15)));
    bus('hE80000, 1'b1, 4'h0);
    n_cmp++;
    if ({configured, obs_oe} !== 2'b00) begin
      n_err++;
      $display("FAIL shutup_ignores: got cfg/oe=%b want 00", {configured, obs_oe});
    end
    for (int j = 0; j < 8; j++) begin
      a = (j < 4) ? (int'($urandom_range('hB00000, 'hDFFFFF)) & ~1) : rand_addr();
      bus(a, 1'b1, 4'h0);
      n_cmp++;
      if ({obs_fast, obs_slow} !== {1'b0, model_slow(a)}) begin
        n_err++;
        $display("FAIL shutup_decode @%h: got fast/slow=%b want 0%b", a, {obs_fast, obs_slow}, model_slow(a));
      end
    end
  endtask

  task automatic test_priority();
    logic [3:0] m, b;
    int a;
    for (int it = 0; it < 8; it++) begin
      m = 4'($urandom_range(1, 15));
      start_mode(m);
      n_cmp++;
      if (cfgout_n !== (model_size(m) > 0)) begin
        n_err++;
        $display("FAIL prio_state mode=%b: cfgout_n got %b want %b", m, cfgout_n, model_size(m) > 0);
      end
      // Latched mode must ignore later jumper changes.
      {mode_8mb, mode_4mb, mode_slow4mb, mode_slow} = 4'($urandom_range(0, 15));
      if (model_size(m) > 0) begin
        bus('hE80002, 1'b1, 4'h0);
        n_cmp++;
        if ({obs_oe, obs_data} !== {1'b1, model_nibble(model_size(m), 2)}) begin
          n_err++;
          $display("FAIL prio_size mode=%b: got oe=%b d=%h want oe=1 d=%h", m, obs_oe, obs_data, model_nibble(model_size(m), 2));
        end
        b = 4'($urandom_range(0, 15));
        bus('hE80048, 1'b0, b);
        m_cfg = 1'b1; m_base = b;
      end
      for (int j = 0; j < 6; j++) begin
        a = (j < 3) ? (int'($urandom_range('hB00000, 'hDFFFFF)) & ~1) : rand_addr();
        if (j == 0) a = int'(m_base) * (1 << 20);
        bus(a, 1'b1, 4'h0);
        n_cmp++;
        if ({obs_fast, obs_slow} !== {model_fast(a), model_slow(a)}) begin
          n_err++;
          $display("FAIL prio_decode mode=%b @%h: got fast/slow=%b want %b%b", m, a, {obs_fast, obs_slow}, model_fast(a), model_slow(a));
        end
      end
    end
  endtask

  task automatic test_reset_midcycle();
    int waited;
    start_mode(4'b1000);
    @(negedge clock);
    addr = 23'h740000; rw = 1'b1; as_n = 1'b0; uds_n = 1'b0;
    waited = 0;
    while (data_oe !== 1'b1 && waited < 10) begin @(negedge clock); waited++; end
    n_cmp++;
    if (data_oe !== 1'b1) begin
      n_err++;
      $display("FAIL midcycle_oe_wait: data_oe got %b want 1 within 10 cycles", data_oe);
    end
    #2 reset = 1'b1; cfgin_n = 1'b1;
    #1;
    n_cmp++;
    if ({data_out, data_oe, cfgout_n, configured} !== 7'b0000010) begin
      n_err++;
      $display("FAIL async_reset_read: got d/oe/cfgout/cfg=%b want 0000010", {data_out, data_oe, cfgout_n, configured});
    end
    as_n = 1'b1; uds_n = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    m_cfg = 1'b0;
    repeat (4) @(negedge clock);
    bus('hE80000, 1'b1, 4'h0);
    n_cmp++;
    if ({cfgout_n, obs_oe} !== 2'b10) begin
      n_err++;
      $display("FAIL back_to_wait: got cfgout_n/oe=%b want 10", {cfgout_n, obs_oe});
    end

    start_mode(4'b1000);
    bus('hE80048, 1'b0, 4'h3);
    @(negedge clock);
    addr = 23'h180000; rw = 1'b1; as_n = 1'b0; uds_n = 1'b0;
    waited = 0;
    while (fast_sel !== 1'b1 && waited < 10) begin @(negedge clock); waited++; end
    n_cmp++;
    if ({fast_sel, configured, cfgout_n} !== 3'b110) begin
      n_err++;
      $display("FAIL midcycle_fast_wait: got fast/cfg/cfgout=%b want 110", {fast_sel, configured, cfgout_n});
    end
    #2 reset = 1'b1; cfgin_n = 1'b1;
    #1;
    n_cmp++;
    if ({fast_sel, slow_sel, configured, cfgout_n} !== 4'b0001) begin
      n_err++;
      $display("FAIL async_reset_fast: got fast/slow/cfg/cfgout=%b want 0001", {fast_sel, slow_sel, configured, cfgout_n});
    end
    as_n = 1'b1; uds_n = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    repeat (2) @(negedge clock);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_autoconf_reads();
    test_configure();
    test_slow_pass();
    test_shutup();
    test_priority();
    test_reset_midcycle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
